// File: rtl/fpdivsqrt_issue_queue.sv
// Tagged request FIFO and one-at-a-time sequencer in front of scalar_fpdivsqrt.
// Optional operand NaN-box sanitising at dequeue is enabled by defining FPDIVSQRT_IQ_NANBOX_EN.
module fpdivsqrt_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [TAG_W-1:0]           req_tag_i,
    input  logic [2:0]                 req_fp_format_i,
    input  logic                       req_is_fdiv_i,
    input  logic [63:0]                req_opa_i,
    input  logic [63:0]                req_opb_i,
    input  logic [2:0]                 req_rm_i,
    output logic                       div_start_valid_o,
    input  logic                       div_start_ready_i,
    output logic [2:0]                 div_fp_format_o,
    output logic                       div_is_fdiv_o,
    output logic [63:0]                div_opa_o,
    output logic [63:0]                div_opb_o,
    output logic [2:0]                 div_rm_o,
    output logic                       div_flush_o,
    input  logic                       div_finish_valid_i,
    output logic                       div_finish_ready_o,
    input  logic [63:0]                div_res_i,
    input  logic [4:0]                 div_fflags_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [TAG_W-1:0]           resp_tag_o,
    output logic [63:0]                resp_res_o,
    output logic [4:0]                 resp_fflags_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [2:0]       fmt;
        logic             is_fdiv;
        logic [63:0]      opa;
        logic [63:0]      opb;
        logic [2:0]       rm;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head_q, head_nxt, head_box, req_entry;
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [1:0]       state;
    logic [TAG_W-1:0] fly_tag;
    logic             empty, enq, deq;

    assign req_entry = '{tag: req_tag_i, fmt: req_fp_format_i, is_fdiv: req_is_fdiv_i,
                         opa: req_opa_i, opb: req_opb_i, rm: req_rm_i};

    assign empty             = (count == '0);
    assign req_ready_o       = (count < CW'(DEPTH));
    assign div_start_valid_o = (state == S_IDLE) && !empty && !flush_i;
    assign enq               = req_valid_i && req_ready_o && !flush_i;
    assign deq               = div_start_valid_o && div_start_ready_i;
    assign rd_ptr_nxt        = deq ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (enq && !deq)
            count_nxt = count + 1'b1;
        else if (deq && !enq)
            count_nxt = count - 1'b1;
    end

    // Registered payload tracks the post-edge head; a lone entry being written this cycle bypasses the array.
    always_comb begin
        head_nxt = head_q;
        if (!flush_i && count_nxt != '0) begin
            if (enq && count_nxt == CW'(1))
                head_nxt = req_entry;
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

`ifdef FPDIVSQRT_IQ_NANBOX_EN
    function automatic logic [63:0] nanbox(input logic [2:0] fmt, input logic [63:0] op);
        if (fmt == 3'b010 && op[63:32] != 32'hFFFF_FFFF)
            return 64'hFFFF_FFFF_7FC0_0000;
        if (fmt == 3'b001 && op[63:16] != 48'hFFFF_FFFF_FFFF)
            return 64'hFFFF_FFFF_FFFF_7E00;
        return op;
    endfunction

    always_comb begin
        head_box     = head_nxt;
        head_box.opa = nanbox(head_nxt.fmt, head_nxt.opa);
        head_box.opb = nanbox(head_nxt.fmt, head_nxt.opb);
    end
`else
    assign head_box = head_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= S_IDLE;
            head_q        <= '0;
            fly_tag       <= '0;
            resp_tag_o    <= '0;
            resp_res_o    <= '0;
            resp_fflags_o <= '0;
        end else begin
            head_q <= head_box;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                state  <= S_IDLE;
            end else begin
                if (enq) begin
                    mem[wr_ptr] <= req_entry;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                rd_ptr <= rd_ptr_nxt;
                count  <= count_nxt;
                case (state)
                    S_IDLE: if (deq) begin
                        fly_tag <= head_q.tag;
                        state   <= S_BUSY;
                    end
                    S_BUSY: if (div_finish_valid_i) begin
                        resp_tag_o    <= fly_tag;
                        resp_res_o    <= div_res_i;
                        resp_fflags_o <= div_fflags_i;
                        state         <= S_RESP;
                    end
                    S_RESP: if (resp_ready_i)
                        state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign div_fp_format_o    = head_q.fmt;
    assign div_is_fdiv_o      = head_q.is_fdiv;
    assign div_opa_o          = head_q.opa;
    assign div_opb_o          = head_q.opb;
    assign div_rm_o           = head_q.rm;
    assign div_flush_o        = flush_i;
    // Finish is drained during a flush so a result racing the kill never wedges the divider.
    assign div_finish_ready_o = (state == S_BUSY) || flush_i;
    assign resp_valid_o       = (state == S_RESP);
    assign count_o            = count;

endmodule

// File: tb/tb_fpdivsqrt_issue_queue.sv
// Scoreboard bench for fpdivsqrt_issue_queue with a behavioural divider stand-in.
module tb_fpdivsqrt_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk, rst_n, flush_i;
    logic req_valid_i, req_ready_o;
    logic [TAG_W-1:0] req_tag_i;
    logic [2:0] req_fp_format_i, req_rm_i;
    logic req_is_fdiv_i;
    logic [63:0] req_opa_i, req_opb_i;
    logic div_start_valid_o, div_start_ready_i;
    logic [2:0] div_fp_format_o, div_rm_o;
    logic div_is_fdiv_o;
    logic [63:0] div_opa_o, div_opb_o;
    logic div_flush_o, div_finish_valid_i, div_finish_ready_o;
    logic [63:0] div_res_i;
    logic [4:0] div_fflags_i;
    logic resp_valid_o, resp_ready_i;
    logic [TAG_W-1:0] resp_tag_o;
    logic [63:0] resp_res_o;
    logic [4:0] resp_fflags_o;
    logic [$clog2(DEPTH):0] count_o;

    fpdivsqrt_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
        .req_fp_format_i(req_fp_format_i), .req_is_fdiv_i(req_is_fdiv_i),
        .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .req_rm_i(req_rm_i),
        .div_start_valid_o(div_start_valid_o), .div_start_ready_i(div_start_ready_i),
        .div_fp_format_o(div_fp_format_o), .div_is_fdiv_o(div_is_fdiv_o),
        .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_rm_o(div_rm_o),
        .div_flush_o(div_flush_o), .div_finish_valid_i(div_finish_valid_i),
        .div_finish_ready_o(div_finish_ready_o), .div_res_i(div_res_i),
        .div_fflags_i(div_fflags_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_tag_o(resp_tag_o), .resp_res_o(resp_res_o), .resp_fflags_o(resp_fflags_o),
        .count_o(count_o)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      res;
        logic [4:0]       ff;
    } resp_t;

    resp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Environment knobs: 0=blocked, 1=always ready, 2=random
    int start_mode = 1;
    int resp_mode  = 1;
    int fin_lat    = 0;
    bit rand_lat   = 0;
    bit force_fin  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: result depends on every payload field so corruption in transit shows up.
    function automatic logic [68:0] dmodel(input logic [2:0] fmt, input logic is_fdiv,
                                           input logic [63:0] opa, input logic [63:0] opb,
                                           input logic [2:0] rm);
        logic [63:0] r;
        r = is_fdiv ? (opa ^ (opb - 64'h3FF0_0000_0000_0000)) : ~opa;
        return {r, rm, fmt[1:0]};
    endfunction

    function automatic logic [63:0] box(input logic [2:0] fmt, input logic [63:0] op);
`ifdef FPDIVSQRT_IQ_NANBOX_EN
        if (fmt == 3'b010 && op[63:32] != 32'hFFFF_FFFF) return 64'hFFFF_FFFF_7FC0_0000;
        if (fmt == 3'b001 && op[63:16] != 48'hFFFF_FFFF_FFFF) return 64'hFFFF_FFFF_FFFF_7E00;
`endif
        return op;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [TAG_W-1:0] tag, input logic [2:0] fmt, input logic is_fdiv,
                        input logic [63:0] opa, input logic [63:0] opb, input logic [2:0] rm);
        bit ok = 0;
        logic [68:0] m;
        req_tag_i = tag; req_fp_format_i = fmt; req_is_fdiv_i = is_fdiv;
        req_opa_i = opa; req_opb_i = opb; req_rm_i = rm; req_valid_i = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            #1;
            if (req_ready_o) begin
                m = dmodel(fmt, is_fdiv, box(fmt, opa), box(fmt, opb), rm);
                exp_q.push_back('{tag: tag, res: m[68:5], ff: m[4:0]});
                ok = 1;
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !resp_valid_o) done = 1;
        end
        if (!done) check("drain_timeout", 128'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    // Divider and response-sink environment
    initial begin
        bit dbusy = 0;
        int dcnt = 0;
        logic [68:0] d = '0;
        div_start_ready_i = 0; div_finish_valid_i = 0; div_res_i = 0; div_fflags_i = 0;
        resp_ready_i = 0;
        forever begin
            @(negedge clk);
            #1;
            div_start_ready_i  = !dbusy && (start_mode == 1 || (start_mode == 2 && $urandom_range(0, 1) == 1));
            div_finish_valid_i = (dbusy && dcnt == 0) || force_fin;
            div_res_i          = d[68:5];
            div_fflags_i       = d[4:0];
            resp_ready_i       = (resp_mode == 1) || (resp_mode == 2 && $urandom_range(0, 2) != 0);
            #1;
            if (!rst_n || div_flush_o) begin
                dbusy = 0;
            end else if (dbusy) begin
                if (div_start_valid_o) check("one_outstanding", 1, 0);
                if (div_finish_valid_i && div_finish_ready_o) dbusy = 0;
                else if (dcnt > 0) dcnt--;
            end else if (div_start_valid_o && div_start_ready_i) begin
                d = dmodel(div_fp_format_o, div_is_fdiv_o, div_opa_o, div_opb_o, div_rm_o);
                dbusy = 1;
                dcnt = rand_lat ? int'($urandom_range(0, 3)) : fin_lat;
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        bit stall = 0;
        resp_t held = '0;
        resp_t got, e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall = 0;
            end else begin
                if (count_o > DEPTH) check("count_bound", 128'(count_o), DEPTH);
                got = '{tag: resp_tag_o, res: resp_res_o, ff: resp_fflags_o};
                if (stall && resp_valid_o) check("resp_stable", 128'(got), 128'(held));
                if (resp_valid_o && resp_ready_i && !flush_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 128'(got), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp", 128'(got), 128'(e));
                    end
                end
                stall = resp_valid_o && !resp_ready_i && !flush_i;
                held  = got;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush_i = 0; req_valid_i = 0; req_tag_i = 0; req_fp_format_i = 0;
        req_is_fdiv_i = 0; req_opa_i = 0; req_opb_i = 0; req_rm_i = 0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_req_ready", 128'(req_ready_o), 1);
        check("rst_start_valid", 128'(div_start_valid_o), 0);
        check("rst_finish_ready", 128'(div_finish_ready_o), 0);
        check("rst_resp_valid", 128'(resp_valid_o), 0);
        check("rst_resp_payload", 128'({resp_tag_o, resp_res_o, resp_fflags_o}), 0);
        check("rst_count", 128'(count_o), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single fp64 divide 2.0 / 1.0
        send(4'd3, 3'b100, 1'b1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'b000);
        drain();

        // Fill with divider blocked
        start_mode = 0;
        for (int i = 0; i < 4; i++)
            send(TAG_W'(i), 3'b100, 1'b1, 64'h4010_0000_0000_0000 + 64'(i), 64'h3FF0_0000_0000_0000, 3'(i));
        #1;
        check("fill_count", 128'(count_o), 4);
        check("fill_ready", 128'(req_ready_o), 0);
        check("fill_head_opa", 128'(div_opa_o), 128'(64'h4010_0000_0000_0000));
        check("fill_start_valid", 128'(div_start_valid_o), 1);
        req_tag_i = 4'd4; req_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("fill_5th_stall", 128'(count_o), 4);
        req_valid_i = 1'b0;
        start_mode = 1;
        drain();

        // Response back-pressure
        resp_mode = 0; fin_lat = 1;
        for (int i = 0; i < 3; i++)
            send(TAG_W'(8 + i), 3'b010, 1'b1, 64'hFFFF_FFFF_4040_0000 + 64'(i), 64'hFFFF_FFFF_3F80_0000, 3'b001);
        for (int i = 0; i < 50 && !resp_valid_o; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        #3;
        check("bp_resp_valid", 128'(resp_valid_o), 1);
        check("bp_start_valid", 128'(div_start_valid_o), 0);
        check("bp_count", 128'(count_o), 2);
        resp_mode = 1;
        drain();

        // Flush while BUSY with three queued entries
        fin_lat = 30;
        for (int i = 0; i < 4; i++)
            send(TAG_W'(i + 1), 3'b100, 1'b0, 64'h4000_0000_0000_0000 + 64'(i), 64'h0, 3'b010);
        #1;
        check("flush_pre_count", 128'(count_o), 3);
        @(negedge clk);
        flush_i = 1; force_fin = 1;
        req_tag_i = 4'd9; req_valid_i = 1'b1;
        exp_q.delete();
        #3;
        check("flush_div_flush", 128'(div_flush_o), 1);
        check("flush_finish_ready", 128'(div_finish_ready_o), 1);
        @(negedge clk);
        flush_i = 0; force_fin = 0; req_valid_i = 0;
        #3;
        check("flush_count", 128'(count_o), 0);
        check("flush_resp_valid", 128'(resp_valid_o), 0);
        check("flush_div_flush_off", 128'(div_flush_o), 0);
        check("flush_start_valid", 128'(div_start_valid_o), 0);
        repeat (10) @(negedge clk);
        fin_lat = 0;
        send(4'd12, 3'b100, 1'b1, 64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b011);
        drain();

        // Operand NaN-box handling at dequeue
        start_mode = 0;
        send(4'd5, 3'b010, 1'b0, 64'h0000_0000_3F80_0000, 64'h0, 3'b000);
        #1;
`ifdef FPDIVSQRT_IQ_NANBOX_EN
        check("nanbox_fp32", 128'(div_opa_o), 128'(64'hFFFF_FFFF_7FC0_0000));
`else
        check("nanbox_fp32", 128'(div_opa_o), 128'(64'h0000_0000_3F80_0000));
`endif
        start_mode = 1;
        drain();
        start_mode = 0;
        send(4'd6, 3'b001, 1'b0, 64'h0000_0000_0000_3C00, 64'h0, 3'b100);
        #1;
`ifdef FPDIVSQRT_IQ_NANBOX_EN
        check("nanbox_fp16", 128'(div_opa_o), 128'(64'hFFFF_FFFF_FFFF_7E00));
`else
        check("nanbox_fp16", 128'(div_opa_o), 128'(64'h0000_0000_0000_3C00));
`endif
        start_mode = 1;
        drain();
        start_mode = 0;
        send(4'd7, 3'b010, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'h0, 3'b000);
        #1;
        check("nanbox_fp32_ok", 128'(div_opa_o), 128'(64'hFFFF_FFFF_3F80_0000));
        start_mode = 1;
        drain();

        // Random traffic with random ready/latency on every channel
        start_mode = 2; resp_mode = 2; rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] fmt;
            case ($urandom_range(0, 2))
                0: fmt = 3'b001;
                1: fmt = 3'b010;
                default: fmt = 3'b100;
            endcase
            send(TAG_W'(i), fmt, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 {$urandom, $urandom}, 3'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Asynchronous reset mid-operation
        start_mode = 1; resp_mode = 1; rand_lat = 0; fin_lat = 5;
        for (int i = 0; i < 3; i++)
            send(TAG_W'(i), 3'b100, 1'b1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'b000);
        @(posedge clk);
        #2;
        rst_n = 0;
        exp_q.delete();
        #1;
        check("areset_count", 128'(count_o), 0);
        check("areset_resp_valid", 128'(resp_valid_o), 0);
        check("areset_start_valid", 128'(div_start_valid_o), 0);
        check("areset_finish_ready", 128'(div_finish_ready_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        fin_lat = 0;
        send(4'd15, 3'b100, 1'b1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'b000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
